mant_div_seq: RTL and testbench

MANT_DIV_SEQ -- requirements
Module: mant_div_seq

---
 rtl/mant_div_seq.sv | 155 +++++++++++++++
 tb/tb_mant_div_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mant_div_seq.sv
// mant_div_seq: sequential restoring divider for unsigned floating-point mantissas.
// Produces floor(a/b) and a mod b, one quotient bit per cycle (WIDTH cycles).
// Ports:
//   clk          single rising-edge clock
//   rst          synchronous active-high reset
//   start        request one division (accepted only when idle)
//   a, b         dividend / divisor mantissas (captured on accept)
//   busy         division in progress
//   done         one-cycle completion pulse
//   quotient     registered floor(a/b); all ones when b==0
//   remainder    registered a mod b; a when b==0
//   div_by_zero  last completed operation had b==0
module mant_div_seq #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic             pend, pend_n;        // DONE entered from b==0, completion not yet flagged
  logic [WIDTH-1:0] dvd, dvd_n;          // captured dividend, shifted out MSB first
  logic [WIDTH-1:0] dvs, dvs_n;          // captured divisor
  logic [WIDTH-1:0] p, p_n;              // partial remainder
  logic [WIDTH-1:0] q, q_n;              // quotient shift register
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_n, done_n, dz_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;

  // Restoring step datapath: T = {P << 1, next dividend bit}, ripple subtract T - divisor.
  logic [WIDTH-1:0] t, diff;
  logic             c, borrow, take;

  always_comb begin
    t      = {p[WIDTH-2:0], dvd[WIDTH-1]};
    c      = p[WIDTH-1];
    diff   = '0;
    borrow = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = t[i] ^ dvs[i] ^ borrow;
      borrow  = (~t[i] & dvs[i]) | (~(t[i] ^ dvs[i]) & borrow);
    end
    // A shifted-out 1 means the true 12-bit value already exceeds the divisor.
    take = c | ~borrow;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    pend_n      = pend;
    dvd_n       = dvd;
    dvs_n       = dvs;
    p_n         = p;
    q_n         = q;
    cnt_n       = cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
    dz_n        = div_by_zero;

    unique case (state)
      IDLE: begin
        if (start) begin
          dvd_n  = a;
          dvs_n  = b;
          busy_n = 1'b1;
          if (b == '0) begin
            state_n = DONE;
            pend_n  = 1'b1;
          end else begin
            state_n = RUN;
            p_n     = '0;
            cnt_n   = '0;
          end
        end
      end

      RUN: begin
        dvd_n = {dvd[WIDTH-2:0], 1'b0};
        p_n   = take ? diff : t;
        q_n   = {q[WIDTH-2:0], take};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_n     = DONE;
          busy_n      = 1'b0;
          done_n      = 1'b1;
          quotient_n  = {q[WIDTH-2:0], take};
          remainder_n = take ? diff : t;
          dz_n        = 1'b0;
        end
      end

      DONE: begin
        if (pend) begin
          // Divide-by-zero completes one cycle after acceptance.
          pend_n      = 1'b0;
          busy_n      = 1'b0;
          done_n      = 1'b1;
          quotient_n  = '1;
          remainder_n = dvd;
          dz_n        = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      p           <= '0;
      q           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      pend        <= pend_n;
      dvd         <= dvd_n;
      dvs         <= dvs_n;
      p           <= p_n;
      q           <= q_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= dz_n;
    end
  end

endmodule

// File: tb/tb_mant_div_seq.sv
// tb_mant_div_seq: directed bench for mant_div_seq with a result scoreboard.
module tb_mant_div_seq;

  localparam int unsigned W = 11;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  mant_div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_q = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_q"}, 32'(quotient), 0);
    check({tag, "_r"}, 32'(remainder), 0);
    check({tag, "_dz"}, 32'(div_by_zero), 0);
  endtask

  // Count done pulses over n cycles; expect none.
  task automatic expect_no_done(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask

  // One full division; optionally pulse start again mid-run with other operands.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit glitch);
    exp_t e;
    exp_t got_e;
    int   cyc = 0;
    bit   busy_drop = 1'b0;
    e.q   = (bv == '0) ? '1 : av / bv;
    e.r   = (bv == '0) ? av : av % bv;
    e.dz  = (bv == '0);
    e.lat = (bv == '0) ? 1 : int'(W);
    sb.push_back(e);

    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    check("busy_after_accept", 32'(busy), 1);
    check("result_hold", 32'(quotient), 32'(last_q));

    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!done && !busy) busy_drop = 1'b1;
      if (glitch && cyc == 3) begin
        start = 1'b1; a = 11'h7FF; b = 11'h001;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;

    check("done_seen", 32'(done), 1);
    check("latency", cyc, e.lat);
    check("busy_held", 32'(busy_drop), 0);
    check("busy_at_done", 32'(busy), 0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      got_e = sb.pop_front();
      check("quotient", 32'(quotient), 32'(got_e.q));
      check("remainder", 32'(remainder), 32'(got_e.r));
      check("div_by_zero", 32'(div_by_zero), 32'(got_e.dz));
      last_q = got_e.q;
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("quotient_hold", 32'(quotient), 32'(last_q));
    if (glitch) expect_no_done("no_second_done", 20);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(11'h064, 11'h007, 1'b0);
    run_op(11'h7FF, 11'h001, 1'b0);
    run_op(11'h7FF, 11'h600, 1'b0);
    run_op(11'h005, 11'h009, 1'b0);
    run_op(11'h7FE, 11'h7FF, 1'b0);
    run_op(11'h123, 11'h000, 1'b0);
    run_op(11'h064, 11'h007, 1'b1);
    run_op(11'h3A5, 11'h011, 1'b0);

    // Reset in the middle of RUN aborts without a done pulse.
    start = 1'b1; a = 11'h2AB; b = 11'h013;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_abort", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("abort");
    last_q = '0;
    expect_no_done("abort_no_done", 15);

    // start in the same edge as reset is discarded.
    rst = 1'b1; start = 1'b1; a = 11'h100; b = 11'h003;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("start_with_rst_busy", 32'(busy), 0);
    expect_no_done("start_with_rst_no_done", 15);

    run_op(11'h7FF, 11'h600, 1'b0);
    run_op(11'h000, 11'h000, 1'b0);
    run_op(11'h400, 11'h400, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
